// File: rtl/peakdetect_acq_ctrl.sv
// Acquisition sequencer for the peak-detect capture path.
// Arms the datapath, fills a circular capture memory with a pre-trigger
// window, waits for a qualified trigger, fills the post-trigger window and
// reports the address of the first post-trigger word.
module peakdetect_acq_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int CLR_CYCLES = 4
) (
  input  logic              DATA_CLK,
  input  logic              CNTCLR,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [31:0]       div_n_cfg,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  input  logic              pd_wr_enable,
  input  logic [127:0]      pd_dataout,
  input  logic              fifo_full,
  output logic              pd_clr,
  output logic [31:0]       div_n_maxmin,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_PRE       = 3'd2,
    S_WAIT_TRIG = 3'd3,
    S_POST      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [3:0]        CLR_LAST = 4'(CLR_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        clr_cnt_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] pre_len_r;
  logic [ADDR_W-1:0] post_len_r;
  logic [ADDR_W-1:0] ptr_nxt_s;
  logic [ADDR_W-1:0] cnt_inc_s;
  logic              writing_s;
  logic              accept_s;
  logic              drop_s;
  logic              start_s;
  logic              trig_hit_s;

  // Beat qualification and pointer/counter increments.
  always_comb begin
    writing_s = (state_r == S_PRE) || (state_r == S_WAIT_TRIG) || (state_r == S_POST);
    accept_s  = writing_s && pd_wr_enable && !fifo_full;
    drop_s    = writing_s && pd_wr_enable && fifo_full;
    cnt_inc_s = cnt_r + ONE_A;
    if (accept_s) begin
      ptr_nxt_s = ptr_r + ONE_A;
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Next-state decode; abort overrides arm and trig.
  always_comb begin
    state_s    = state_r;
    start_s    = 1'b0;
    trig_hit_s = 1'b0;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_s = S_CLEAR;
            start_s = 1'b1;
          end else begin
            state_s = state_r;
          end
        end
        S_CLEAR: begin
          if (clr_cnt_r == CLR_LAST) begin
            state_s = (pre_len_r == ZERO_A) ? S_WAIT_TRIG : S_PRE;
          end else begin
            state_s = S_CLEAR;
          end
        end
        S_PRE: begin
          if (accept_s && (cnt_inc_s == pre_len_r)) begin
            state_s = S_WAIT_TRIG;
          end else begin
            state_s = S_PRE;
          end
        end
        S_WAIT_TRIG: begin
          if (trig) begin
            trig_hit_s = 1'b1;
            state_s    = (post_len_r == ZERO_A) ? S_DONE : S_POST;
          end else begin
            state_s = S_WAIT_TRIG;
          end
        end
        S_POST: begin
          if (accept_s && (cnt_inc_s == post_len_r)) begin
            state_s = S_DONE;
          end else begin
            state_s = S_POST;
          end
        end
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge DATA_CLK) begin
    if (CNTCLR) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Sequencing counters, latched configuration and status outputs.
  always_ff @(posedge DATA_CLK) begin
    if (CNTCLR) begin
      clr_cnt_r    <= 4'd0;
      cnt_r        <= ZERO_A;
      pre_len_r    <= ZERO_A;
      post_len_r   <= ZERO_A;
      div_n_maxmin <= 32'd1;
      pd_clr       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      trig_addr    <= ZERO_A;
    end else begin
      if (start_s) begin
        clr_cnt_r    <= 4'd0;
        div_n_maxmin <= div_n_cfg;
        pre_len_r    <= pre_len;
        post_len_r   <= post_len;
      end else if (state_r == S_CLEAR) begin
        clr_cnt_r <= clr_cnt_r + 4'd1;
      end
      // Phase counter restarts on every state change so each window counts from zero.
      if (state_s != state_r) begin
        cnt_r <= ZERO_A;
      end else if (accept_s && ((state_r == S_PRE) || (state_r == S_POST))) begin
        cnt_r <= cnt_inc_s;
      end
      if (start_s) begin
        overflow <= 1'b0;
      end else if (drop_s) begin
        overflow <= 1'b1;
      end
      // A beat accepted together with the trigger belongs to the pre-trigger window.
      if (trig_hit_s) begin
        trig_addr <= ptr_nxt_s;
      end
      pd_clr <= (state_s == S_CLEAR);
      busy   <= (state_s != S_IDLE) && (state_s != S_DONE);
      done   <= (state_s == S_DONE);
    end
  end

  // Capture write port: one-cycle registered write of each accepted beat.
  always_ff @(posedge DATA_CLK) begin
    if (CNTCLR) begin
      ptr_r    <= ZERO_A;
      mem_wen  <= 1'b0;
      mem_addr <= ZERO_A;
      mem_data <= 128'd0;
    end else begin
      mem_wen <= accept_s;
      if (accept_s) begin
        mem_addr <= ptr_r;
        mem_data <= pd_dataout;
      end
      if (start_s) begin
        ptr_r <= ZERO_A;
      end else begin
        ptr_r <= ptr_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_peakdetect_acq_ctrl.sv
// Scoreboard bench for peakdetect_acq_ctrl: a 12-bit-address instance for the
// main scenarios and a 4-bit-address instance for the wrap scenario.
module tb_peakdetect_acq_ctrl;

  typedef struct packed {
    logic [11:0]  addr;
    logic [127:0] data;
  } exp_t;

  logic         DATA_CLK = 1'b0;
  logic         CNTCLR;
  logic         arm;
  logic         abort;
  logic         trig;
  logic [31:0]  div_n_cfg;
  logic [11:0]  pre_len;
  logic [11:0]  post_len;
  logic         pd_wr_enable;
  logic [127:0] pd_dataout;
  logic         fifo_full;

  logic         pd_clr, mem_wen, busy, done, overflow;
  logic [31:0]  div_n_maxmin;
  logic [11:0]  mem_addr, trig_addr;
  logic [127:0] mem_data;

  logic         w_pd_clr, w_mem_wen, w_busy, w_done, w_overflow;
  logic [31:0]  w_div_n_maxmin;
  logic [3:0]   w_mem_addr, w_trig_addr;
  logic [127:0] w_mem_data;

  exp_t       q[$];
  exp_t       q_w[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_wen    = 0;
  int         exp_ptr  = 0;
  logic       chk_w    = 1'b0;
  logic [3:0] last_w_addr = 4'd0;

  always #5 DATA_CLK = ~DATA_CLK;

  peakdetect_acq_ctrl #(.ADDR_W(12), .CLR_CYCLES(4)) dut (
    .DATA_CLK(DATA_CLK), .CNTCLR(CNTCLR), .arm(arm), .abort(abort), .trig(trig),
    .div_n_cfg(div_n_cfg), .pre_len(pre_len), .post_len(post_len),
    .pd_wr_enable(pd_wr_enable), .pd_dataout(pd_dataout), .fifo_full(fifo_full),
    .pd_clr(pd_clr), .div_n_maxmin(div_n_maxmin), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_data(mem_data), .trig_addr(trig_addr),
    .busy(busy), .done(done), .overflow(overflow)
  );

  peakdetect_acq_ctrl #(.ADDR_W(4), .CLR_CYCLES(4)) dut_w (
    .DATA_CLK(DATA_CLK), .CNTCLR(CNTCLR), .arm(arm), .abort(abort), .trig(trig),
    .div_n_cfg(div_n_cfg), .pre_len(pre_len[3:0]), .post_len(post_len[3:0]),
    .pd_wr_enable(pd_wr_enable), .pd_dataout(pd_dataout), .fifo_full(fifo_full),
    .pd_clr(w_pd_clr), .div_n_maxmin(w_div_n_maxmin), .mem_wen(w_mem_wen),
    .mem_addr(w_mem_addr), .mem_data(w_mem_data), .trig_addr(w_trig_addr),
    .busy(w_busy), .done(w_done), .overflow(w_overflow)
  );

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Write monitor: every capture write must match the oldest expected beat.
  always @(negedge DATA_CLK) begin
    exp_t e;
    if (mem_wen === 1'b1) begin
      n_wen++;
      if (q.size() == 0) begin
        check_eq("unexpected_wen", 128'(q.size()), 128'd1);
      end else begin
        e = q.pop_front();
        check_eq("wr_addr", 128'(mem_addr), 128'(e.addr));
        check_eq("wr_data", mem_data, e.data);
      end
    end
    if (chk_w && (w_mem_wen === 1'b1)) begin
      last_w_addr = w_mem_addr;
      if (q_w.size() == 0) begin
        check_eq("w_unexpected_wen", 128'(q_w.size()), 128'd1);
      end else begin
        e = q_w.pop_front();
        check_eq("w_wr_addr", 128'(w_mem_addr), 128'(e.addr));
        check_eq("w_wr_data", w_mem_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge DATA_CLK);
    #1;
  endtask

  // One cycle of datapath stimulus; a beat the design should accept is queued.
  task automatic drive(input logic en, input logic full);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    pd_wr_enable = en;
    fifo_full    = full;
    pd_dataout   = d;
    if (en && !full) begin
      q.push_back({12'(exp_ptr), d});
      if (chk_w) q_w.push_back({12'(exp_ptr & 15), d});
      exp_ptr++;
    end
    tick();
    pd_wr_enable = 1'b0;
    fifo_full    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic pulse_trig(input logic with_beat);
    trig = 1'b1;
    drive(with_beat, 1'b0);
    trig = 1'b0;
  endtask

  // Arm, then scramble host config and hold pd_wr_enable high through the clear window.
  task automatic do_arm(input logic [31:0] div, input logic [11:0] pre, input logic [11:0] post);
    int cnt;
    div_n_cfg = div;
    pre_len   = pre;
    post_len  = post;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    div_n_cfg = 32'hDEAD_BEEF;
    pre_len   = 12'd3;
    post_len  = 12'd2;
    exp_ptr   = 0;
    cnt       = 0;
    pd_wr_enable = 1'b1;
    while ((pd_clr === 1'b1) && (cnt < 20)) begin
      cnt++;
      tick();
    end
    pd_wr_enable = 1'b0;
    check_eq("clr_cycles", 128'(cnt), 128'd4);
    check_eq("div_latched", 128'(div_n_maxmin), 128'(div));
    check_eq("busy_after_clr", 128'(busy), 128'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_div"},   128'(div_n_maxmin), 128'd1);
    check_eq({tag, "_pdclr"}, 128'(pd_clr), 128'd0);
    check_eq({tag, "_wen"},   128'(mem_wen), 128'd0);
    check_eq({tag, "_addr"},  128'(mem_addr), 128'd0);
    check_eq({tag, "_data"},  mem_data, 128'd0);
    check_eq({tag, "_taddr"}, 128'(trig_addr), 128'd0);
    check_eq({tag, "_busy"},  128'(busy), 128'd0);
    check_eq({tag, "_done"},  128'(done), 128'd0);
    check_eq({tag, "_ovf"},   128'(overflow), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    CNTCLR = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    div_n_cfg = 32'd0; pre_len = 12'd0; post_len = 12'd0;
    pd_wr_enable = 1'b0; pd_dataout = 128'd0; fifo_full = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    CNTCLR = 1'b0;
    tick();

    // Basic: beats every 4th cycle, trigger ~10 cycles into WAIT_TRIG.
    n_wen = 0;
    do_arm(32'd100, 12'd8, 12'd16);
    repeat (8) begin idle(3); drive(1'b1, 1'b0); end
    for (int i = 0; i < 10; i++) begin
      if ((i % 4) == 3) drive(1'b1, 1'b0);
      else idle(1);
    end
    check_eq("t1_not_done_pre_trig", 128'(done), 128'd0);
    pulse_trig(1'b0);
    repeat (16) begin idle(3); drive(1'b1, 1'b0); end
    check_eq("t1_done", 128'(done), 128'd1);
    check_eq("t1_busy", 128'(busy), 128'd0);
    check_eq("t1_trig_addr", 128'(trig_addr), 128'd10);
    check_eq("t1_ovf", 128'(overflow), 128'd0);
    idle(4);
    check_eq("t1_wen_count", 128'(n_wen), 128'd26);
    check_eq("t1_q_empty", 128'(q.size()), 128'd0);

    // Trigger during PRE is ignored; trigger with a same-cycle beat counts it as pre.
    do_arm(32'd7, 12'd20, 12'd4);
    repeat (5) drive(1'b1, 1'b0);
    pulse_trig(1'b0);
    repeat (15) drive(1'b1, 1'b0);
    check_eq("t2_not_done", 128'(done), 128'd0);
    check_eq("t2_busy", 128'(busy), 128'd1);
    idle(2);
    pulse_trig(1'b1);
    repeat (4) drive(1'b1, 1'b0);
    check_eq("t2_done", 128'(done), 128'd1);
    check_eq("t2_trig_addr", 128'(trig_addr), 128'd21);
    idle(2);
    check_eq("t2_q_empty", 128'(q.size()), 128'd0);

    // Wrap on the 16-word instance.
    CNTCLR = 1'b1;
    tick();
    CNTCLR = 1'b0;
    chk_w = 1'b1;
    do_arm(32'd5, 12'd10, 12'd5);
    repeat (30) drive(1'b1, 1'b0);
    pulse_trig(1'b0);
    repeat (5) drive(1'b1, 1'b0);
    idle(2);
    check_eq("t3_w_trig_addr", 128'(w_trig_addr), 128'd14);
    check_eq("t3_w_done", 128'(w_done), 128'd1);
    check_eq("t3_w_last_addr", 128'(last_w_addr), 128'd2);
    check_eq("t3_trig_addr", 128'(trig_addr), 128'd30);
    check_eq("t3_w_q_empty", 128'(q_w.size()), 128'd0);
    check_eq("t3_q_empty", 128'(q.size()), 128'd0);
    chk_w = 1'b0;

    // Backpressure in POST: dropped beats are not written and set sticky overflow.
    do_arm(32'd9, 12'd2, 12'd6);
    repeat (2) drive(1'b1, 1'b0);
    pulse_trig(1'b0);
    repeat (2) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    check_eq("t4_ovf_set", 128'(overflow), 128'd1);
    check_eq("t4_not_done", 128'(done), 128'd0);
    repeat (4) drive(1'b1, 1'b0);
    check_eq("t4_done", 128'(done), 128'd1);
    check_eq("t4_ovf_sticky", 128'(overflow), 128'd1);
    check_eq("t4_trig_addr", 128'(trig_addr), 128'd2);
    idle(2);
    check_eq("t4_q_empty", 128'(q.size()), 128'd0);

    // Zero lengths: straight to WAIT_TRIG, trigger completes with no writes.
    do_arm(32'd1, 12'd0, 12'd0);
    check_eq("t5_ovf_cleared", 128'(overflow), 128'd0);
    check_eq("t5_done_cleared", 128'(done), 128'd0);
    idle(2);
    pulse_trig(1'b0);
    check_eq("t5_done", 128'(done), 128'd1);
    check_eq("t5_busy", 128'(busy), 128'd0);
    check_eq("t5_trig_addr", 128'(trig_addr), 128'd0);
    idle(3);

    // Abort in POST together with trig and arm; the beat of that cycle still drains.
    do_arm(32'd3, 12'd2, 12'd8);
    repeat (2) drive(1'b1, 1'b0);
    pulse_trig(1'b0);
    repeat (3) drive(1'b1, 1'b0);
    abort = 1'b1; trig = 1'b1; arm = 1'b1;
    drive(1'b1, 1'b0);
    abort = 1'b0; trig = 1'b0; arm = 1'b0;
    check_eq("t6_busy", 128'(busy), 128'd0);
    check_eq("t6_done", 128'(done), 128'd0);
    check_eq("t6_pdclr", 128'(pd_clr), 128'd0);
    idle(2);
    check_eq("t6_arm_ignored", 128'(pd_clr), 128'd0);
    check_eq("t6_div_held", 128'(div_n_maxmin), 128'd3);
    check_eq("t6_q_empty", 128'(q.size()), 128'd0);

    // Reset mid-PRE with an in-flight beat and overflow set.
    do_arm(32'd55, 12'd20, 12'd4);
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    check_eq("t7_ovf_pre", 128'(overflow), 128'd1);
    CNTCLR = 1'b1;
    pd_wr_enable = 1'b1;
    pd_dataout = {$urandom, $urandom, $urandom, $urandom};
    tick();
    pd_wr_enable = 1'b0;
    check_reset_vals("t7");
    CNTCLR = 1'b0;
    idle(2);
    check_eq("t7_q_empty", 128'(q.size()), 128'd0);
    check_eq("t7_busy", 128'(busy), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
